// File: rtl/dmem_bus_ctrl_if.sv
// Memory-stage request/response and external bus signals for the data memory controller.
// The controller takes the master modport; the memory stage and bus model take the slave side.
interface dmem_bus_ctrl_if;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        stall_req_o;
    logic        err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    modport master (
        input  ce_i, we_i, addr_i, wdata_i, bus_ack_i, bus_rdata_i,
        output rdata_o, stall_req_o, err_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
    );

    modport slave (
        output ce_i, we_i, addr_i, wdata_i, bus_ack_i, bus_rdata_i,
        input  rdata_o, stall_req_o, err_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
    );
endinterface

// File: rtl/dmem_bus_ctrl.sv
// Data memory bus controller: stalls the pipeline while a word access is outstanding on the bus,
// rejects misaligned accesses and aborts a transfer that is not acknowledged within TIMEOUT_CYC cycles.
module dmem_bus_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic           clk,
    input  logic           rst,
    dmem_bus_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic        to_q;
    logic        req_q, we_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        stall, err;
    logic        aligned, limit;

    assign aligned = (bus.addr_i[1:0] == 2'b00);
    assign limit   = (cnt_q == 8'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        err     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ce_i) begin
                    if (aligned) begin
                        stall   = 1'b1;
                        state_d = BUSY;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                // an ack in the limit cycle still completes the transfer normally
                if (bus.bus_ack_i || limit) state_d = DONE;
            end
            DONE: begin
                err     = to_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            to_q    <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.ce_i && aligned) begin
                        req_q   <= 1'b1;
                        we_q    <= bus.we_i;
                        addr_q  <= bus.addr_i;
                        wdata_q <= bus.wdata_i;
                        cnt_q   <= 8'd0;
                    end
                end
                BUSY: begin
                    if (bus.bus_ack_i) begin
                        req_q <= 1'b0;
                        if (!we_q) rdata_q <= bus.bus_rdata_i;
                    end else if (limit) begin
                        req_q <= 1'b0;
                        to_q  <= 1'b1;
                        if (!we_q) rdata_q <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: to_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.stall_req_o = stall & ~rst;
    assign bus.err_o       = err & ~rst;
    assign bus.rdata_o     = rdata_q;
    assign bus.bus_req_o   = req_q;
    assign bus.bus_we_o    = we_q;
    assign bus.bus_addr_o  = addr_q;
    assign bus.bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Randomized self-checking bench for dmem_bus_ctrl with a transaction-level reference model
// (stall count, error and load result derived from the ack delay of each access).
module tb_dmem_bus_ctrl;
    localparam int TO = 4;
    localparam int NO_ACK = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_rdata = 32'd0;

    dmem_bus_ctrl_if bif();

    dmem_bus_ctrl #(.TIMEOUT_CYC(TO)) dut (.clk(clk), .rst(rst), .bus(bif.master));

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bif.ce_i = 1'b0; bif.we_i = 1'b0; bif.addr_i = 32'd0; bif.wdata_i = 32'd0;
        bif.bus_ack_i = 1'b0; bif.bus_rdata_i = 32'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // One access starting in an IDLE cycle; ack is pulsed in BUSY cycle d (0-based), or never if d >= TO.
    // Returns at #1 after the edge that leaves DONE.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input int d, input logic [31:0] rd, input bit done_ack, input string nm);
        int cyc = 0, stalls = 0;
        bit done = 0;
        int exp_stalls = (d < TO) ? d + 2 : TO + 1;
        logic exp_err = (d >= TO);
        bif.ce_i = 1'b1; bif.we_i = we; bif.addr_i = addr; bif.wdata_i = wd;
        while (!done && cyc < 300) begin
            bif.bus_ack_i = (cyc == d + 1) || (done_ack && cyc == exp_stalls);
            bif.bus_rdata_i = (cyc == d + 1) ? rd : $urandom;
            @(negedge clk);
            if (bif.stall_req_o) begin
                stalls++;
                if (cyc >= 1) begin
                    checks++;
                    if (bif.bus_req_o !== 1'b1 || bif.bus_addr_o !== addr || bif.bus_we_o !== we ||
                        bif.bus_wdata_o !== wd) begin
                        failures++;
                        $display("FAIL %s busy_bus cyc=%0d got req=%b addr=%h we=%b wd=%h want req=1 addr=%h we=%b wd=%h",
                                 nm, cyc, bif.bus_req_o, bif.bus_addr_o, bif.bus_we_o, bif.bus_wdata_o, addr, we, wd);
                    end
                end
                checks++;
                if (bif.err_o !== 1'b0) begin
                    failures++;
                    $display("FAIL %s err_during_stall got %b want 0", nm, bif.err_o);
                end
            end else begin
                done = 1;
                if (!we) exp_rdata = exp_err ? 32'd0 : rd;
                checks++;
                if (stalls != exp_stalls) begin
                    failures++;
                    $display("FAIL %s stall_cycles got %0d want %0d", nm, stalls, exp_stalls);
                end
                checks++;
                if (bif.err_o !== exp_err) begin
                    failures++;
                    $display("FAIL %s done_err got %b want %b", nm, bif.err_o, exp_err);
                end
                checks++;
                if (bif.rdata_o !== exp_rdata) begin
                    failures++;
                    $display("FAIL %s done_rdata got %h want %h", nm, bif.rdata_o, exp_rdata);
                end
                checks++;
                if (bif.bus_req_o !== 1'b0) begin
                    failures++;
                    $display("FAIL %s done_req got %b want 0", nm, bif.bus_req_o);
                end
            end
            next_cycle();
            bif.ce_i = 1'b0;
            bif.bus_ack_i = 1'b0;
            cyc++;
        end
        if (!done) begin
            failures++;
            $display("FAIL %s timeout_wait got no DONE within %0d cycles want DONE", nm, cyc);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #12;
        checks++;
        if (bif.rdata_o !== 32'd0 || bif.bus_req_o !== 1'b0 || bif.bus_we_o !== 1'b0 ||
            bif.bus_addr_o !== 32'd0 || bif.bus_wdata_o !== 32'd0 || bif.stall_req_o !== 1'b0 || bif.err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got rdata=%h req=%b we=%b addr=%h wd=%h stall=%b err=%b want all 0",
                     bif.rdata_o, bif.bus_req_o, bif.bus_we_o, bif.bus_addr_o, bif.bus_wdata_o, bif.stall_req_o, bif.err_o);
        end
        @(negedge clk); rst = 1'b0;
        exp_rdata = 32'd0;
        next_cycle();
    endtask

    task automatic test_load();
        run_txn(1'b0, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF, 0, "load");
    endtask

    task automatic test_store();
        run_txn(1'b1, 32'h0000_0040, 32'h1234_5678, 0, 32'hFFFF_0000, 0, "store");
    endtask

    task automatic test_misaligned(input logic [31:0] addr);
        bif.ce_i = 1'b1; bif.we_i = $urandom; bif.addr_i = addr; bif.wdata_i = $urandom;
        @(negedge clk);
        checks++;
        if (bif.err_o !== 1'b1 || bif.stall_req_o !== 1'b0 || bif.bus_req_o !== 1'b0) begin
            failures++;
            $display("FAIL misaligned addr=%h got err=%b stall=%b req=%b want err=1 stall=0 req=0",
                     addr, bif.err_o, bif.stall_req_o, bif.bus_req_o);
        end
        next_cycle();
        bif.ce_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bif.err_o !== 1'b0 || bif.stall_req_o !== 1'b0 || bif.bus_req_o !== 1'b0 || bif.rdata_o !== exp_rdata) begin
            failures++;
            $display("FAIL misaligned_after got err=%b stall=%b req=%b rdata=%h want 0 0 0 %h",
                     bif.err_o, bif.stall_req_o, bif.bus_req_o, bif.rdata_o, exp_rdata);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 32'h0000_0200, 32'h0, NO_ACK, 32'h0, 0, "timeout");
        @(negedge clk);
        checks++;
        if (bif.err_o !== 1'b0 || bif.stall_req_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_idle got err=%b stall=%b want 0 0", bif.err_o, bif.stall_req_o);
        end
        next_cycle();
    endtask

    task automatic test_ack_at_limit();
        run_txn(1'b0, 32'h0000_0300, 32'h0, TO - 1, 32'hA5A5_A5A5, 0, "ack_limit");
    endtask

    task automatic test_spurious_ack();
        run_txn(1'b0, 32'h0000_0400, 32'h0, 1, 32'h0BAD_F00D, 1, "done_ack");
        bif.bus_ack_i = 1'b1; bif.bus_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (bif.rdata_o !== exp_rdata || bif.stall_req_o !== 1'b0 || bif.bus_req_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_ack got rdata=%h stall=%b req=%b want %h 0 0",
                     bif.rdata_o, bif.stall_req_o, bif.bus_req_o, exp_rdata);
        end
        next_cycle();
        bif.bus_ack_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bif.rdata_o !== exp_rdata || bif.stall_req_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_ack_after got rdata=%h stall=%b want %h 0", bif.rdata_o, bif.stall_req_o, exp_rdata);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_busy();
        bif.ce_i = 1'b1; bif.we_i = 1'b0; bif.addr_i = 32'h0000_0500;
        next_cycle();
        bif.ce_i = 1'b0;
        next_cycle();
        next_cycle();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bif.bus_req_o !== 1'b0 || bif.stall_req_o !== 1'b0 || bif.err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got req=%b stall=%b err=%b want 0 0 0", bif.bus_req_o, bif.stall_req_o, bif.err_o);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        exp_rdata = 32'd0;
        next_cycle();
        bif.bus_ack_i = 1'b1; bif.bus_rdata_i = 32'hCAFE_CAFE;
        @(negedge clk);
        checks++;
        if (bif.rdata_o !== 32'd0 || bif.stall_req_o !== 1'b0 || bif.bus_req_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_late_ack got rdata=%h stall=%b req=%b want 0 0 0", bif.rdata_o, bif.stall_req_o, bif.bus_req_o);
        end
        next_cycle();
        bif.bus_ack_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bif.rdata_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_late_ack_after got rdata=%h want 0", bif.rdata_o);
        end
        next_cycle();
        run_txn(1'b0, 32'h0000_0504, 32'h0, 2, 32'h1357_9BDF, 0, "post_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                test_misaligned({$urandom} | 32'h1);
            end else begin
                logic we = $urandom;
                int d = $urandom_range(0, TO + 1);
                run_txn(we, {$urandom} & 32'hFFFF_FFFC, $urandom, (d >= TO) ? NO_ACK : d, $urandom,
                        $urandom_range(0, 1), "random");
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_misaligned(32'h0000_0102);
        test_timeout();
        test_ack_at_limit();
        test_spurious_ack();
        test_reset_mid_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
